simplez_ctrl_unit: RTL and testbench
====================================

// Module: simplez_ctrl_unit
// PURPOSE
//  Microprogram-free (hardwired) control unit for the SIMPLEZ CPU. Sequences the full
//  8-instruction ISA (ST, LD, ADD, BR, BZ, CLR, DEC, HALT) by driving every datapath
//  microorder (RA, CP, RI, AC, ALU, MP). Replaces the inline sequencer inside the top-level
//  CPU and adds a memory-ready wait handshake and HALT resume. Sits between RI/AC flags and the datapath.
// PARAMETERS
//  CO_W     3  opcode width (RI[11:9])
//  ALUOP_W  2  ALU operation select width
// PORTS
//  clk      in   1        system clock; all state updates on negedge clk (datapath samples same edge)
//  rstn     in   1        asynchronous, active-low reset
//  co       in   CO_W     opcode field of RI
//  z        in   1        AC==0 flag from datapath
//  mem_rdy  in   1        MP access completes this cycle (tie 1 for single-cycle BRAM)
//  run      in   1        one-cycle pulse: leave HALT
//  lec      out  1        MP read
//  esc      out  1        MP write
//  era      out  1        load RA from busAi
//  eri      out  1        load RI from busD
//  sri      out  1        drive CD onto busAi
//  scp      out  1        drive CP onto busAi
//  ecp      out  1        load CP from busAi
//  incp     out  1        CP <= CP+1
//  eac      out  1        load AC from ALU
//  sac      out  1        drive AC onto busD
//  alu_op   out  ALUOP_W  0=TRA2(busD) 1=SUM(AC+busD) 2=DEC1(AC-1) 3=ZERO
//  stop     out  1        CPU halted
// BEHAVIOUR
//  - States: I0 fetch, I1 decode/exec, O0 operand access, O1 end-of-cycle, HLT. 3-bit reg.
//  - rstn low (async): state=I0; while rstn low all outputs forced 0. alu_op=0.
//  - Outputs are combinational from (state, co, z, mem_rdy); any microorder not listed is 0.
//  - I0: lec=1. If mem_rdy: eri=1, incp=1, ->I1; else hold I0 (eri/incp stay 0, fire exactly once).
//  - I1 by co:
//     ST/LD/ADD: sri=1, era=1 ->O0
//     BR:        sri=1, era=1, ecp=1 ->I0
//     BZ:        z=1: as BR; z=0: scp=1, era=1 ->I0
//     CLR:       eac=1, alu_op=ZERO, scp=1, era=1 ->I0
//     DEC:       eac=1, alu_op=DEC1, scp=1, era=1 ->I0
//     HALT:      stop=1 ->HLT
//  - O0: ST: sac=1, esc=1; LD: lec=1, alu_op=TRA2; ADD: lec=1, alu_op=SUM.
//     If mem_rdy: LD/ADD add eac=1, ->O1; else hold O0 (eac 0, esc/lec held).
//     co is stable in O0 (RI not written outside I0).
//  - O1: scp=1, era=1 ->I0 (RA <= CP for next fetch).
//  - HLT: stop=1; run=1 ->O1 (reload RA from CP, resume at next instr); else hold.
//  - run ignored in every state except HLT. Illegal state encoding ->I0.
//  - Latency (mem_rdy=1): CLR/DEC/BR/BZ 2 cycles; ST/LD/ADD 4 cycles; HALT reached 2 cycles after I0.
//  - Each wait cycle with mem_rdy=0 adds 1 cycle in I0/O0; no side effects repeat.
//  - Async reset mid-instruction aborts it; CP/RA/RI reset by datapath, fetch restarts at 0.
// STRUCTURE
//  - simplez_pkg: opcode constants (ST=0..HALT=7), state encodings, ALU_TRA2/SUM/DEC1/ZERO.
//  - One natural sub-module: simplez_opdec (co -> is_mem, is_branch, is_alu1, is_halt), combinational.
//  - Top: state register (async reset) + next-state/output always @* block.
// TESTING
//  - Reset: rstn=0 mid-O0 -> all outputs 0 immediately; release -> I0, lec=1 on first cycle.
//  - LD at mem_rdy=1: I0(lec,eri,incp) I1(sri,era) O0(lec,eac,alu_op=0) O1(scp,era); 4 cycles.
//  - ST with mem_rdy low 3 cycles in O0 -> esc,sac held 4 cycles, then O1; incp pulsed once total.
//  - BZ z=1 -> I1 asserts sri,era,ecp, next state I0; BZ z=0 -> scp,era only, no ecp.
//  - DEC then CLR back-to-back -> alu_op=2 then 3 with eac=1 in each I1; 2 cycles per instruction.
//  - HALT: stop=1 held 20 cycles, run=0; run pulse -> O1 (scp,era) then I0 fetch, stop=0.

Source files
------------

// File: rtl/simplez_pkg.sv
// ---------------------------------------------------------------------------
// Module : simplez_pkg
// Brief  : Shared constants and types for the SIMPLEZ hardwired control unit
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package simplez_pkg;

  localparam int CO_W    = 3;
  localparam int ALUOP_W = 2;

  // Opcodes as found in RI[11:9]
  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  // ALU operation select
  localparam logic [1:0] ALU_TRA2 = 2'd0;
  localparam logic [1:0] ALU_SUM  = 2'd1;
  localparam logic [1:0] ALU_DEC1 = 2'd2;
  localparam logic [1:0] ALU_ZERO = 2'd3;

  // Sequencer states
  typedef enum logic [2:0] {
    S_I0  = 3'd0,
    S_I1  = 3'd1,
    S_O0  = 3'd2,
    S_O1  = 3'd3,
    S_HLT = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/simplez_opdec.sv
// ---------------------------------------------------------------------------
// Module : simplez_opdec
// Brief  : Classifies a SIMPLEZ opcode into instruction groups
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module simplez_opdec
  import simplez_pkg::*;
#(
  parameter int CO_W = 3
) (
  input  logic [CO_W-1:0] co,
  output logic            is_mem,
  output logic            is_branch,
  output logic            is_alu1,
  output logic            is_halt
);

  // Group decode: memory-operand, branch, single-operand ALU, halt
  always_comb begin
    is_mem    = 1'b0;
    is_branch = 1'b0;
    is_alu1   = 1'b0;
    is_halt   = 1'b0;
    case (co)
      OP_ST, OP_LD, OP_ADD: is_mem    = 1'b1;
      OP_BR, OP_BZ:         is_branch = 1'b1;
      OP_CLR, OP_DEC:       is_alu1   = 1'b1;
      OP_HALT:              is_halt   = 1'b1;
      default:              is_halt   = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/simplez_ctrl_unit.sv
// ---------------------------------------------------------------------------
// Module : simplez_ctrl_unit
// Brief  : Hardwired sequencer for the SIMPLEZ CPU with memory-ready wait
//          states and HALT resume. Outputs are decoded combinationally from
//          the current state and inputs; state advances on the falling edge,
//          the same edge on which the datapath samples the microorders.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module simplez_ctrl_unit
  import simplez_pkg::*;
#(
  parameter int CO_W    = 3,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [CO_W-1:0]    co,
  input  logic               z,
  input  logic               mem_rdy,
  input  logic               run,
  output logic               lec,
  output logic               esc,
  output logic               era,
  output logic               eri,
  output logic               sri,
  output logic               scp,
  output logic               ecp,
  output logic               incp,
  output logic               eac,
  output logic               sac,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               stop
);

  state_t state;
  state_t state_nxt;

  logic is_mem;
  logic is_branch;
  logic is_alu1;
  logic is_halt;

  // Ungated microorders; masked by rstn before leaving the block
  logic               lec_c, esc_c, era_c, eri_c, sri_c, scp_c;
  logic               ecp_c, incp_c, eac_c, sac_c, stop_c;
  logic [ALUOP_W-1:0] alu_c;

  simplez_opdec #(
    .CO_W (CO_W)
  ) u_opdec (
    .co        (co),
    .is_mem    (is_mem),
    .is_branch (is_branch),
    .is_alu1   (is_alu1),
    .is_halt   (is_halt)
  );

  // State register, advanced on the falling edge alongside the datapath
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_I0;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and microorder decode
  always_comb begin
    state_nxt = state;
    lec_c     = 1'b0;
    esc_c     = 1'b0;
    era_c     = 1'b0;
    eri_c     = 1'b0;
    sri_c     = 1'b0;
    scp_c     = 1'b0;
    ecp_c     = 1'b0;
    incp_c    = 1'b0;
    eac_c     = 1'b0;
    sac_c     = 1'b0;
    stop_c    = 1'b0;
    alu_c     = ALUOP_W'(ALU_TRA2);

    case (state)
      S_I0: begin
        // Fetch: RI and CP update only on the cycle the read completes
        lec_c = 1'b1;
        if (mem_rdy) begin
          eri_c     = 1'b1;
          incp_c    = 1'b1;
          state_nxt = S_I1;
        end
      end

      S_I1: begin
        if (is_mem) begin
          sri_c     = 1'b1;
          era_c     = 1'b1;
          state_nxt = S_O0;
        end else if (is_branch) begin
          era_c = 1'b1;
          if ((co == CO_W'(OP_BR)) || z) begin
            sri_c = 1'b1;
            ecp_c = 1'b1;
          end else begin
            scp_c = 1'b1;
          end
          state_nxt = S_I0;
        end else if (is_alu1) begin
          eac_c     = 1'b1;
          alu_c     = (co == CO_W'(OP_CLR)) ? ALUOP_W'(ALU_ZERO) : ALUOP_W'(ALU_DEC1);
          scp_c     = 1'b1;
          era_c     = 1'b1;
          state_nxt = S_I0;
        end else if (is_halt) begin
          stop_c    = 1'b1;
          state_nxt = S_HLT;
        end else begin
          state_nxt = S_I0;
        end
      end

      S_O0: begin
        // Operand access; strobes held until the memory completes
        if (co == CO_W'(OP_ST)) begin
          sac_c = 1'b1;
          esc_c = 1'b1;
        end else begin
          lec_c = 1'b1;
          alu_c = (co == CO_W'(OP_ADD)) ? ALUOP_W'(ALU_SUM) : ALUOP_W'(ALU_TRA2);
        end
        if (mem_rdy) begin
          eac_c     = (co != CO_W'(OP_ST));
          state_nxt = S_O1;
        end
      end

      S_O1: begin
        // Point RA back at CP for the next fetch
        scp_c     = 1'b1;
        era_c     = 1'b1;
        state_nxt = S_I0;
      end

      S_HLT: begin
        stop_c = 1'b1;
        if (run) begin
          state_nxt = S_O1;
        end
      end

      default: begin
        state_nxt = S_I0;
      end
    endcase
  end

  // Everything is held low while reset is asserted
  assign lec    = rstn & lec_c;
  assign esc    = rstn & esc_c;
  assign era    = rstn & era_c;
  assign eri    = rstn & eri_c;
  assign sri    = rstn & sri_c;
  assign scp    = rstn & scp_c;
  assign ecp    = rstn & ecp_c;
  assign incp   = rstn & incp_c;
  assign eac    = rstn & eac_c;
  assign sac    = rstn & sac_c;
  assign stop   = rstn & stop_c;
  assign alu_op = rstn ? alu_c : '0;

endmodule

`default_nettype wire

// File: tb/tb_simplez_ctrl_unit.sv
// ---------------------------------------------------------------------------
// Module : tb_simplez_ctrl_unit
// Brief  : Self-checking bench for simplez_ctrl_unit
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_simplez_ctrl_unit;

  // Output vector layout: {lec,esc,era,eri,sri,scp,ecp,incp,eac,sac,alu_op[1:0],stop}
  localparam logic [12:0] LEC   = 13'h1000;
  localparam logic [12:0] ESC   = 13'h0800;
  localparam logic [12:0] ERA   = 13'h0400;
  localparam logic [12:0] ERI   = 13'h0200;
  localparam logic [12:0] SRI   = 13'h0100;
  localparam logic [12:0] SCP   = 13'h0080;
  localparam logic [12:0] ECP   = 13'h0040;
  localparam logic [12:0] INCP  = 13'h0020;
  localparam logic [12:0] EAC   = 13'h0010;
  localparam logic [12:0] SAC   = 13'h0008;
  localparam logic [12:0] A_SUM = 13'h0002;
  localparam logic [12:0] A_DEC = 13'h0004;
  localparam logic [12:0] A_ZER = 13'h0006;
  localparam logic [12:0] STOP  = 13'h0001;
  localparam logic [12:0] NONE  = 13'h0000;
  localparam logic [12:0] FETCH = LEC | ERI | INCP;

  localparam logic [2:0] ST = 3'd0, LD = 3'd1, ADD = 3'd2, BR = 3'd3;
  localparam logic [2:0] BZ = 3'd4, CLR = 3'd5, DEC = 3'd6, HLT = 3'd7;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] co = 3'd0;
  logic       z = 1'b0;
  logic       mem_rdy = 1'b0;
  logic       run = 1'b0;
  logic       lec, esc, era, eri, sri, scp, ecp, incp, eac, sac, stop;
  logic [1:0] alu_op;

  int n_checks = 0;
  int n_fail   = 0;
  int incp_cnt = 0;

  wire [12:0] act = {lec, esc, era, eri, sri, scp, ecp, incp, eac, sac, alu_op, stop};

  typedef struct {
    logic [2:0]  co;
    logic        z;
    logic        rdy;
    logic        run;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];

  simplez_ctrl_unit dut (
    .clk     (clk),
    .rstn    (rstn),
    .co      (co),
    .z       (z),
    .mem_rdy (mem_rdy),
    .run     (run),
    .lec     (lec),
    .esc     (esc),
    .era     (era),
    .eri     (eri),
    .sri     (sri),
    .scp     (scp),
    .ecp     (ecp),
    .incp    (incp),
    .eac     (eac),
    .sac     (sac),
    .alu_op  (alu_op),
    .stop    (stop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected %b", name, got, want);
    end
  endtask

  // Entered just after a falling edge: drive, sample at the rising edge,
  // then move past the next falling edge where the state advances.
  task automatic step(input string name, input logic [2:0] c, input logic zz,
                      input logic rdy, input logic rr, input logic [12:0] want);
    co      = c;
    z       = zz;
    mem_rdy = rdy;
    run     = rr;
    @(posedge clk);
    #1;
    if (incp === 1'b1) incp_cnt++;
    check(name, act, want);
    @(negedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [2:0] c, input logic zz, input logic rdy,
                               input logic rr, input logic [12:0] e);
    vec_t v;
    v.co = c; v.z = zz; v.rdy = rdy; v.run = rr; v.exp = e;
    return v;
  endfunction

  initial begin
    // LD, single-cycle memory
    tbl.push_back(mkv(LD, 0, 1, 0, FETCH));
    tbl.push_back(mkv(LD, 0, 1, 0, SRI | ERA));
    tbl.push_back(mkv(LD, 0, 1, 0, LEC | EAC));
    tbl.push_back(mkv(LD, 0, 1, 0, SCP | ERA));
    // ADD with a fetch wait (run must be ignored) and an operand wait
    tbl.push_back(mkv(ADD, 0, 0, 0, LEC));
    tbl.push_back(mkv(ADD, 0, 0, 1, LEC));
    tbl.push_back(mkv(ADD, 0, 1, 0, FETCH));
    tbl.push_back(mkv(ADD, 0, 1, 0, SRI | ERA));
    tbl.push_back(mkv(ADD, 0, 0, 0, LEC | A_SUM));
    tbl.push_back(mkv(ADD, 0, 1, 0, LEC | EAC | A_SUM));
    tbl.push_back(mkv(ADD, 0, 1, 0, SCP | ERA));
    // BZ taken, BZ not taken, BR
    tbl.push_back(mkv(BZ, 1, 1, 0, FETCH));
    tbl.push_back(mkv(BZ, 1, 1, 0, SRI | ERA | ECP));
    tbl.push_back(mkv(BZ, 0, 1, 0, FETCH));
    tbl.push_back(mkv(BZ, 0, 1, 0, SCP | ERA));
    tbl.push_back(mkv(BR, 0, 1, 0, FETCH));
    tbl.push_back(mkv(BR, 0, 1, 0, SRI | ERA | ECP));
    // DEC then CLR back to back (run pulse in I1 ignored)
    tbl.push_back(mkv(DEC, 0, 1, 0, FETCH));
    tbl.push_back(mkv(DEC, 0, 1, 1, EAC | A_DEC | SCP | ERA));
    tbl.push_back(mkv(CLR, 0, 1, 0, FETCH));
    tbl.push_back(mkv(CLR, 0, 1, 0, EAC | A_ZER | SCP | ERA));

    // Reset state: everything low while rstn is asserted
    @(negedge clk);
    #1;
    check("reset_outputs", act, NONE);
    rstn = 1'b1;
    step("first_fetch_wait", LD, 0, 0, 0, LEC);

    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].co, tbl[i].z, tbl[i].rdy, tbl[i].run, tbl[i].exp);
    end

    // ST with three operand wait cycles; incp must pulse once only
    incp_cnt = 0;
    step("st_fetch", ST, 0, 1, 0, FETCH);
    step("st_i1", ST, 0, 1, 0, SRI | ERA);
    for (int k = 0; k < 3; k++) begin
      step($sformatf("st_wait%0d", k), ST, 0, 0, 0, SAC | ESC);
    end
    step("st_done", ST, 0, 1, 0, SAC | ESC);
    step("st_o1", ST, 0, 1, 0, SCP | ERA);
    n_checks++;
    if (incp_cnt != 1) begin
      n_fail++;
      $display("FAIL st_incp_count: got %0d expected 1", incp_cnt);
    end

    // HALT: stop held with run low, then resume through O1
    step("halt_fetch", HLT, 0, 1, 0, FETCH);
    step("halt_i1", HLT, 0, 1, 0, STOP);
    for (int k = 0; k < 20; k++) begin
      step($sformatf("halt_hold%0d", k), HLT, 0, 1, 0, STOP);
    end
    step("halt_run", HLT, 0, 1, 1, STOP);
    step("halt_o1", HLT, 0, 1, 0, SCP | ERA);
    step("halt_refetch", LD, 0, 1, 0, FETCH);

    // Asynchronous reset in the middle of an operand wait
    step("rst_ld_i1", LD, 0, 1, 0, SRI | ERA);
    co = LD; z = 1'b0; mem_rdy = 1'b0; run = 1'b0;
    @(posedge clk);
    #1;
    check("rst_pre_o0", act, LEC);
    rstn = 1'b0;
    #1;
    check("rst_mid_o0", act, NONE);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    step("rst_restart_fetch", CLR, 0, 1, 0, FETCH);
    step("rst_restart_i1", CLR, 0, 1, 0, EAC | A_ZER | SCP | ERA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
